// File: rtl/ppu_lcd_scaler_vout.sv
// LCD raster timing + integer upscaler reading a double-buffered frame buffer; outputs lag the counters by RD_LAT+1 clocks.
// Free-running pixel stream with no backpressure; page swaps and mirror changes only take effect at a frame boundary.
module ppu_lcd_scaler_vout #(
  parameter int H_TOTAL  = 1056,
  parameter int H_SYNC   = 30,
  parameter int H_START  = 46,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 13,
  parameter int V_START  = 23,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int SRC_XB   = 8,
  parameter int SRC_YB   = 8,
  parameter int SCALE_SH = 1,
  parameter int RD_LAT   = 1,
  parameter int PIX_W    = 8,
  parameter logic [PIX_W-1:0] BORDER = '0
) (
  input  logic                     i_lcd_clk,
  input  logic                     i_lcd_rst,
  input  logic [1:0]               i_mirror,
  input  logic                     i_swap_req,
  output logic                     o_swap_ack,
  output logic [SRC_YB+SRC_XB:0]   o_vbuf_addr,
  output logic                     o_vbuf_rd,
  input  logic [PIX_W-1:0]         i_vbuf_q,
  output logic [PIX_W-1:0]         o_pix,
  output logic                     o_hsd,
  output logic                     o_vsd,
  output logic                     o_de,
  output logic                     o_vblank
);

  localparam int X_WIN = (1 << SRC_XB) << SCALE_SH;
  localparam int Y_WIN = (1 << SRC_YB) << SCALE_SH;
  localparam int XW = $clog2(((H_TOTAL > X_WIN) ? H_TOTAL : X_WIN) + 1);
  localparam int YW = $clog2(((V_TOTAL > Y_WIN) ? V_TOTAL : Y_WIN) + 1);

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_SYNC = XW'(H_SYNC);
  localparam logic [XW-1:0] X_BEG  = XW'(H_START);
  localparam logic [XW-1:0] X_END  = XW'(H_START + H_ACTIVE);
  localparam logic [XW-1:0] X_AMAX = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_WLIM = XW'(X_WIN);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_SYNC = YW'(V_SYNC);
  localparam logic [YW-1:0] Y_BEG  = YW'(V_START);
  localparam logic [YW-1:0] Y_END  = YW'(V_START + V_ACTIVE);
  localparam logic [YW-1:0] Y_AMAX = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] Y_WLIM = YW'(Y_WIN);

  typedef enum logic {IDLE, PENDING} pg_state_t;

  logic [XW-1:0] xcnt, ax, axp;
  logic [YW-1:0] ycnt, ay, ayp;
  logic          frame_end, hsd_raw, vsd_raw, de_raw, win_raw;
  logic [1:0]    mir_q;
  logic          page;
  pg_state_t     pg_state;
  logic [RD_LAT-1:0][3:0] pipe_q;
  logic [3:0]    tail;

  assign frame_end = (xcnt == X_LAST) && (ycnt == Y_LAST);
  assign hsd_raw   = (xcnt >= X_SYNC);
  assign vsd_raw   = (ycnt >= Y_SYNC);
  assign de_raw    = hsd_raw && vsd_raw && (xcnt >= X_BEG) && (xcnt < X_END)
                     && (ycnt >= Y_BEG) && (ycnt < Y_END);

  // Outside the active area these wrap to garbage, but win_raw gates the strobe.
  assign ax  = xcnt - X_BEG;
  assign ay  = ycnt - Y_BEG;
  assign axp = mir_q[0] ? (X_AMAX - ax) : ax;
  assign ayp = mir_q[1] ? (Y_AMAX - ay) : ay;
  assign win_raw = de_raw && (axp < X_WLIM) && (ayp < Y_WLIM);

  assign o_vbuf_addr = {page, SRC_YB'(ayp >> SCALE_SH), SRC_XB'(axp >> SCALE_SH)};
  assign o_vbuf_rd   = win_raw;

  always_ff @(posedge i_lcd_clk or posedge i_lcd_rst) begin
    if (i_lcd_rst) begin
      xcnt <= '0;
      ycnt <= '0;
    end else if (xcnt == X_LAST) begin
      xcnt <= '0;
      ycnt <= (ycnt == Y_LAST) ? '0 : ycnt + YW'(1);
    end else begin
      xcnt <= xcnt + XW'(1);
    end
  end

  // Mirror is latched only on the last pixel so a frame is never drawn half-flipped.
  always_ff @(posedge i_lcd_clk or posedge i_lcd_rst) begin
    if (i_lcd_rst) begin
      mir_q <= '0;
    end else if (frame_end) begin
      mir_q <= i_mirror;
    end
  end

  always_ff @(posedge i_lcd_clk or posedge i_lcd_rst) begin
    if (i_lcd_rst) begin
      pg_state   <= IDLE;
      page       <= 1'b0;
      o_swap_ack <= 1'b0;
    end else begin
      o_swap_ack <= 1'b0;
      case (pg_state)
        IDLE: begin
          if (i_swap_req) begin
            if (frame_end) begin
              page       <= ~page;
              o_swap_ack <= 1'b1;
            end else begin
              pg_state <= PENDING;
            end
          end
        end
        PENDING: begin
          if (frame_end) begin
            page       <= ~page;
            o_swap_ack <= 1'b1;
            pg_state   <= IDLE;
          end
        end
        default: pg_state <= IDLE;
      endcase
    end
  end

  // Delay line matches the frame-buffer read latency so timing and data line up.
  always_ff @(posedge i_lcd_clk or posedge i_lcd_rst) begin
    if (i_lcd_rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= {hsd_raw, vsd_raw, de_raw, win_raw};
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail = pipe_q[RD_LAT-1];

  always_ff @(posedge i_lcd_clk or posedge i_lcd_rst) begin
    if (i_lcd_rst) begin
      o_hsd    <= 1'b0;
      o_vsd    <= 1'b0;
      o_de     <= 1'b0;
      o_pix    <= '0;
      o_vblank <= 1'b0;
    end else begin
      o_hsd    <= tail[3];
      o_vsd    <= tail[2];
      o_de     <= tail[1];
      o_pix    <= tail[0] ? i_vbuf_q : (tail[1] ? BORDER : '0);
      o_vblank <= (ycnt < Y_BEG) || (ycnt >= Y_END);
    end
  end

endmodule

// File: tb/tb_ppu_lcd_scaler_vout.sv
// Directed bench: short-frame timing, two DUTs (RD_LAT=1/SCALE_SH=1 and RD_LAT=3/SCALE_SH=0) sharing one clock.
module tb_ppu_lcd_scaler_vout;
  localparam int HT    = 1056;
  localparam int VT    = 12;
  localparam int VS    = 1;
  localparam int VST   = 3;
  localparam int VA    = 6;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst2, swap1, swap2;
  logic [1:0]  mir1, mir2;
  logic        ack1, ack2, rd1, rd2, hsd1, hsd2, vsd1, vsd2, de1, de2, vb1, vb2;
  logic [16:0] addr1, addr2;
  logic [7:0]  q1, q2, pix1, pix2;
  logic [16:0] a1_d, a2_d1, a2_d2, a2_d3;
  int          tx, ty;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [7:0] fpix(input logic [16:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ (a[16] ? 8'hA5 : 8'h00) ^ 8'h3C;
  endfunction

  // Frame-buffer models with 1- and 3-clock read latency.
  always @(posedge clk) begin
    a1_d  <= addr1;
    a2_d1 <= addr2;
    a2_d2 <= a2_d1;
    a2_d3 <= a2_d2;
  end
  assign q1 = fpix(a1_d);
  assign q2 = fpix(a2_d3);

  // Reference raster position of DUT 1 during the current cycle.
  always @(posedge clk or posedge rst1) begin
    if (rst1) begin
      tx <= 0;
      ty <= 0;
    end else if (tx == HT - 1) begin
      tx <= 0;
      ty <= (ty == VT - 1) ? 0 : ty + 1;
    end else begin
      tx <= tx + 1;
    end
  end

  ppu_lcd_scaler_vout #(
    .H_TOTAL(HT), .H_SYNC(30), .H_START(46), .V_TOTAL(VT), .V_SYNC(VS), .V_START(VST),
    .H_ACTIVE(800), .V_ACTIVE(VA), .SRC_XB(8), .SRC_YB(8), .SCALE_SH(1), .RD_LAT(1),
    .PIX_W(8), .BORDER(8'hEE)
  ) dut1 (
    .i_lcd_clk(clk), .i_lcd_rst(rst1), .i_mirror(mir1), .i_swap_req(swap1),
    .o_swap_ack(ack1), .o_vbuf_addr(addr1), .o_vbuf_rd(rd1), .i_vbuf_q(q1),
    .o_pix(pix1), .o_hsd(hsd1), .o_vsd(vsd1), .o_de(de1), .o_vblank(vb1)
  );

  ppu_lcd_scaler_vout #(
    .H_TOTAL(HT), .H_SYNC(30), .H_START(46), .V_TOTAL(VT), .V_SYNC(VS), .V_START(VST),
    .H_ACTIVE(800), .V_ACTIVE(VA), .SRC_XB(8), .SRC_YB(8), .SCALE_SH(0), .RD_LAT(3),
    .PIX_W(8), .BORDER(8'hEE)
  ) dut2 (
    .i_lcd_clk(clk), .i_lcd_rst(rst2), .i_mirror(mir2), .i_swap_req(swap2),
    .o_swap_ack(ack2), .o_vbuf_addr(addr2), .o_vbuf_rd(rd2), .i_vbuf_q(q2),
    .o_pix(pix2), .o_hsd(hsd2), .o_vsd(vsd2), .o_de(de2), .o_vblank(vb2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(input int x, input int y);
    int n = 0;
    while (!(tx == x && ty == y) && n < 2 * FRAME) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2 * FRAME) begin
      checks++;
      errors++;
      $error("FAIL timeout_at observed=%0d,%0d expected=%0d,%0d", tx, ty, x, y);
    end
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    swap1 = 1'b0; swap2 = 1'b0;
    mir1 = 2'b00; mir2 = 2'b00;
    step(3);
    check("rst_hsd", hsd1, 0);
    check("rst_vsd", vsd1, 0);
    check("rst_de", de1, 0);
    check("rst_pix", pix1, 0);
    check("rst_ack", ack1, 0);
    check("rst_vblank", vb1, 0);
    check("rst_rd", rd1, 0);
    check("rst_page", addr1[16], 0);
    rst1 = 1'b0; rst2 = 1'b0;

    // Frame 0
    check("vblank_pre", vb1, 0);
    at(1, 0);    check("vblank_top", vb1, 1);
    at(31, 0);   check("hsd_low", hsd1, 0);
    at(32, 0);   check("hsd_high", hsd1, 1);
    at(1, 1);    check("vsd_low", vsd1, 0);
    at(2, 1);    check("vsd_high", vsd1, 1);
    at(45, 3);   check("rd_before", rd1, 0);
    at(46, 3);   check("addr_first", addr1, 17'h00000);
                 check("rd_first", rd1, 1);
                 check("addr2_first", addr2, 17'h00000);
                 check("rd2_first", rd2, 1);
    at(47, 3);   check("de_not_yet", de1, 0);
    at(48, 3);   check("de_rise", de1, 1);
                 check("pix_first", pix1, 8'h3C);
    at(49, 3);   check("de2_not_yet", de2, 0);
    at(50, 3);   check("de2_rise", de2, 1);
                 check("pix2_first", pix2, 8'h3C);
    at(100, 3);  check("vblank_active", vb1, 0);
    at(56, 4);   check("addr2_mid", addr2, 17'h0010A);
                 check("rd2_mid", rd2, 1);
    at(60, 4);   check("pix2_lat4", pix2, 8'h26);
    at(302, 4);  check("rd2_edge", rd2, 0);
    at(306, 4);  check("pix2_border", pix2, 8'hEE);
                 check("de2_border", de2, 1);
    at(67, 6);   check("addr_scaled", addr1, 17'h0010A);
                 check("rd_scaled", rd1, 1);
    at(69, 6);   check("pix_scaled", pix1, 8'h26);
    at(557, 6);  check("addr_ax511", addr1, 17'h001FF);
                 check("rd_ax511", rd1, 1);
    at(558, 6);  check("rd_ax512", rd1, 0);
    at(560, 6);  check("de_border", de1, 1);
                 check("pix_border", pix1, 8'hEE);
    at(846, 6);  check("rd_ax800", rd1, 0);
    at(847, 6);  check("pix_last_border", pix1, 8'hEE);
    at(848, 6);  check("de_ax800", de1, 0);
                 check("pix_ax800", pix1, 0);
    at(900, 6);  mir1 = 2'b01;
    at(334, 7);  check("addr_noflip_yet", addr1, 17'h00290);
                 check("rd_noflip_yet", rd1, 1);
    at(1000, 7); swap1 = 1'b1; step(1); swap1 = 1'b0;
    at(1000, 8); swap1 = 1'b1; step(1); swap1 = 1'b0;
    at(0, 9);    check("vblank_last_active", vb1, 0);
    at(1, 9);    check("vblank_bottom", vb1, 1);
    at(1055, 11); check("ack_before_end", ack1, 0);
                  check("page_before_end", addr1[16], 0);

    // Frame 1: x-flip and page 1 in effect
    at(0, 0);    check("ack_pulse", ack1, 1);
    at(1, 0);    check("ack_single", ack1, 0);
    at(46, 3);   check("rd_flip_ax0", rd1, 0);
                 check("page_toggled", addr1[16], 1);
    at(48, 3);   check("pix_flip_border", pix1, 8'hEE);
    at(334, 3);  check("addr_flip_ax288", addr1, 17'h100FF);
                 check("rd_flip_ax288", rd1, 1);
    at(336, 3);  check("pix_flip_ax288", pix1, 8'h66);
    at(400, 3);  mir1 = 2'b00;

    // Frame 2: no further swap; then request on the frame-end cycle itself
    at(0, 0);    check("no_second_ack", ack1, 0);
    at(46, 3);   check("addr_page1", addr1, 17'h10000);
                 check("rd_page1", rd1, 1);
    at(1055, 11); check("page_hold", addr1[16], 1);
                  swap1 = 1'b1; step(1); swap1 = 1'b0;
    check("ack_edge_req", ack1, 1);
    check("page_edge_req", addr1[16], 0);
    step(1);     check("ack_edge_single", ack1, 0);

    // Frame 3: reset DUT 2 mid-line with a swap pending
    at(400, 4);  swap2 = 1'b1; step(1); swap2 = 1'b0;
    at(500, 4);  check("de2_pre_reset", de2, 1);
    rst2 = 1'b1;
    #1;
    check("rst2_de", de2, 0);
    check("rst2_pix", pix2, 0);
    check("rst2_hsd", hsd2, 0);
    check("rst2_vsd", vsd2, 0);
    check("rst2_rd", rd2, 0);
    check("rst2_ack", ack2, 0);
    check("rst2_vblank", vb2, 0);
    step(2);
    rst2 = 1'b0;
    step(1);     check("rst2_restart_vblank", vb2, 1);
    step(32);    check("rst2_hsd_low", hsd2, 0);
    step(1);     check("rst2_hsd_high", hsd2, 1);
    step(FRAME - 34);
    check("rst2_swap_dropped_ack", ack2, 0);
    check("rst2_swap_dropped_page", addr2[16], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
